// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// mc_ctrl_pkg : encodings shared by the MIPS-31 multi-cycle control unit
// Revision 1.0
// ----------------------------------------------------------------------
package mc_ctrl_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0011;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_NOR  = 4'b0111;
  localparam logic [3:0] ALUC_LUI  = 4'b1000;
  localparam logic [3:0] ALUC_SLTU = 4'b1010;
  localparam logic [3:0] ALUC_SLT  = 4'b1011;
  localparam logic [3:0] ALUC_SRA  = 4'b1100;
  localparam logic [3:0] ALUC_SRL  = 4'b1101;
  localparam logic [3:0] ALUC_SLL  = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic       A_RS      = 1'b0;
  localparam logic       A_SHAMT   = 1'b1;
  localparam logic [1:0] B_RT      = 2'd0;
  localparam logic [1:0] B_SEXT    = 2'd1;
  localparam logic [1:0] B_ZEXT    = 2'd2;
  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;
  localparam logic [1:0] WA_RD     = 2'd0;
  localparam logic [1:0] WA_RT     = 2'd1;
  localparam logic [1:0] WA_RA     = 2'd2;
  localparam logic [1:0] WD_ALU    = 2'd0;
  localparam logic [1:0] WD_MEM    = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;

  typedef enum logic [3:0] {
    CLS_RALU, CLS_IALU, CLS_BEQ, CLS_BNE, CLS_J,
    CLS_JAL, CLS_JR, CLS_LW, CLS_SW, CLS_ILL
  } instr_cls_e;

  typedef struct packed {
    instr_cls_e cls;
    logic [3:0] aluc;
    logic       a_sel;
    logic [1:0] b_sel;
    logic [1:0] waddr_sel;
    logic       ovf_trap;
    logic       illegal;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// mc_ctrl_if : control-unit bus towards IR, ALU, PC, register file, dmem
// Revision 1.0
// ----------------------------------------------------------------------
interface mc_ctrl_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        alu_overflow;
  logic        dmem_ack;
  logic [3:0]  aluc;
  logic        alu_a_sel;
  logic [1:0]  alu_b_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  rf_waddr_sel;
  logic [1:0]  rf_wdata_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic [2:0]  state;
  logic        halted;

  modport master (
    input  instr, alu_zero, alu_overflow, dmem_ack,
    output aluc, alu_a_sel, alu_b_sel, ir_we, pc_we, pc_sel, rf_we,
           rf_waddr_sel, rf_wdata_sel, dmem_req, dmem_we, state, halted
  );

  modport slave (
    output instr, alu_zero, alu_overflow, dmem_ack,
    input  aluc, alu_a_sel, alu_b_sel, ir_we, pc_we, pc_sel, rf_we,
           rf_waddr_sel, rf_wdata_sel, dmem_req, dmem_we, state, halted
  );
endinterface
`default_nettype wire

// File: rtl/mc_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------
// mc_decoder : combinational instruction decode for the MIPS-31 subset
// Revision 1.0
// ----------------------------------------------------------------------
module mc_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_unused_fields;

  assign w_op            = instr[31:26];
  assign w_fn            = instr[5:0];
  assign w_unused_fields = ^instr[25:6];

  always_comb begin
    dec.cls       = CLS_ILL;
    dec.aluc      = ALUC_ADDU;
    dec.a_sel     = A_RS;
    dec.b_sel     = B_RT;
    dec.waddr_sel = WA_RT;
    dec.ovf_trap  = 1'b0;
    dec.illegal   = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        dec.cls       = CLS_RALU;
        dec.waddr_sel = WA_RD;
        case (w_fn)
          FN_ADD:  begin dec.aluc = ALUC_ADD; dec.ovf_trap = 1'b1; end
          FN_ADDU: dec.aluc = ALUC_ADDU;
          FN_SUB:  begin dec.aluc = ALUC_SUB; dec.ovf_trap = 1'b1; end
          FN_SUBU: dec.aluc = ALUC_SUBU;
          FN_AND:  dec.aluc = ALUC_AND;
          FN_OR:   dec.aluc = ALUC_OR;
          FN_XOR:  dec.aluc = ALUC_XOR;
          FN_NOR:  dec.aluc = ALUC_NOR;
          FN_SLT:  dec.aluc = ALUC_SLT;
          FN_SLTU: dec.aluc = ALUC_SLTU;
          FN_SLL:  begin dec.aluc = ALUC_SLL; dec.a_sel = A_SHAMT; end
          FN_SRL:  begin dec.aluc = ALUC_SRL; dec.a_sel = A_SHAMT; end
          FN_SRA:  begin dec.aluc = ALUC_SRA; dec.a_sel = A_SHAMT; end
          FN_SLLV: dec.aluc = ALUC_SLL;
          FN_SRLV: dec.aluc = ALUC_SRL;
          FN_SRAV: dec.aluc = ALUC_SRA;
          FN_JR:   dec.cls  = CLS_JR;
          default: dec.cls  = CLS_ILL;
        endcase
      end
      OP_J:     dec.cls = CLS_J;
      OP_JAL:   begin dec.cls = CLS_JAL; dec.waddr_sel = WA_RA; end
      OP_BEQ:   begin dec.cls = CLS_BEQ; dec.aluc = ALUC_SUBU; end
      OP_BNE:   begin dec.cls = CLS_BNE; dec.aluc = ALUC_SUBU; end
      OP_ADDI:  begin dec.cls = CLS_IALU; dec.aluc = ALUC_ADD;  dec.b_sel = B_SEXT; dec.ovf_trap = 1'b1; end
      OP_ADDIU: begin dec.cls = CLS_IALU; dec.aluc = ALUC_ADDU; dec.b_sel = B_SEXT; end
      OP_SLTI:  begin dec.cls = CLS_IALU; dec.aluc = ALUC_SLT;  dec.b_sel = B_SEXT; end
      OP_SLTIU: begin dec.cls = CLS_IALU; dec.aluc = ALUC_SLTU; dec.b_sel = B_SEXT; end
      OP_ANDI:  begin dec.cls = CLS_IALU; dec.aluc = ALUC_AND;  dec.b_sel = B_ZEXT; end
      OP_ORI:   begin dec.cls = CLS_IALU; dec.aluc = ALUC_OR;   dec.b_sel = B_ZEXT; end
      OP_XORI:  begin dec.cls = CLS_IALU; dec.aluc = ALUC_XOR;  dec.b_sel = B_ZEXT; end
      // lui feeds the raw immediate to the ALU, which does the shift itself
      OP_LUI:   begin dec.cls = CLS_IALU; dec.aluc = ALUC_LUI;  dec.b_sel = B_ZEXT; end
      OP_LW:    begin dec.cls = CLS_LW;   dec.aluc = ALUC_ADDU; dec.b_sel = B_SEXT; end
      OP_SW:    begin dec.cls = CLS_SW;   dec.aluc = ALUC_ADDU; dec.b_sel = B_SEXT; end
      default:  dec.cls = CLS_ILL;
    endcase
    dec.illegal = (dec.cls == CLS_ILL);
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// mc_ctrl : FETCH/DECODE/EXEC/MEM/WB sequencer with dmem wait watchdog
// Revision 1.0
// ----------------------------------------------------------------------
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.master  bus
);

  localparam logic [7:0] C_WAIT_MAX = 8'(MEM_WAIT_MAX);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [7:0] r_wait_cnt;
  logic       r_halted;
  logic       w_taken;
  logic       w_wait_expired;
  dec_t       w_dec;

  mc_decoder u_decoder (
    .instr (bus.instr),
    .dec   (w_dec)
  );

  assign w_taken = ((w_dec.cls == CLS_BEQ) &&  bus.alu_zero) ||
                   ((w_dec.cls == CLS_BNE) && !bus.alu_zero);
  // The counter holds completed MEM cycles, so +1 includes the current one
  assign w_wait_expired = (r_wait_cnt + 8'd1) >= C_WAIT_MAX;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_FETCH;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == ST_HALT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_MEM) || bus.dmem_ack) begin
      r_wait_cnt <= 8'd0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_dec.illegal) begin
          w_next = ST_HALT;
        end else if (w_dec.cls inside {CLS_J, CLS_JAL, CLS_JR}) begin
          w_next = ST_FETCH;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_dec.cls inside {CLS_BEQ, CLS_BNE}) begin
          w_next = ST_FETCH;
        end else if (w_dec.cls inside {CLS_LW, CLS_SW}) begin
          w_next = ST_MEM;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.dmem_ack) begin
          w_next = (w_dec.cls == CLS_LW) ? ST_WB : ST_FETCH;
        end else if (w_wait_expired) begin
          w_next = ST_HALT;
        end
      end
      ST_WB:   w_next = ST_FETCH;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_HALT;
    endcase
  end

  always_comb begin
    bus.aluc         = ALUC_ADDU;
    bus.alu_a_sel    = A_RS;
    bus.alu_b_sel    = B_RT;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.pc_sel       = PC_SEQ;
    bus.rf_we        = 1'b0;
    bus.rf_waddr_sel = WA_RD;
    bus.rf_wdata_sel = WD_ALU;
    bus.dmem_req     = 1'b0;
    bus.dmem_we      = 1'b0;
    if (!rst) begin
      if (r_state inside {ST_EXEC, ST_MEM, ST_WB}) begin
        bus.aluc      = w_dec.aluc;
        bus.alu_a_sel = w_dec.a_sel;
        bus.alu_b_sel = w_dec.b_sel;
      end
      case (r_state)
        ST_FETCH: begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
        end
        ST_DECODE: begin
          case (w_dec.cls)
            CLS_J: begin
              bus.pc_we  = 1'b1;
              bus.pc_sel = PC_JUMP;
            end
            CLS_JAL: begin
              bus.pc_we        = 1'b1;
              bus.pc_sel       = PC_JUMP;
              bus.rf_we        = 1'b1;
              bus.rf_waddr_sel = WA_RA;
              bus.rf_wdata_sel = WD_PC;
            end
            CLS_JR: begin
              bus.pc_we  = 1'b1;
              bus.pc_sel = PC_RS;
            end
            default: ;
          endcase
        end
        ST_EXEC: begin
          if (w_taken) begin
            bus.pc_we  = 1'b1;
            bus.pc_sel = PC_BRANCH;
          end
        end
        ST_MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = (w_dec.cls == CLS_SW);
        end
        ST_WB: begin
          bus.rf_we        = !(w_dec.ovf_trap && bus.alu_overflow);
          bus.rf_waddr_sel = w_dec.waddr_sel;
          bus.rf_wdata_sel = (w_dec.cls == CLS_LW) ? WD_MEM : WD_ALU;
        end
        default: ;
      endcase
    end
  end

  assign bus.state  = r_state;
  assign bus.halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_mc_ctrl : table-driven instruction model checked every cycle
// Revision 1.0
// ----------------------------------------------------------------------
module tb_mc_ctrl;

  localparam int WAIT_MAX = 15;
  localparam int K_R = 0, K_I = 1, K_BR = 2, K_J = 3, K_JAL = 4, K_JR = 5, K_LW = 6, K_SW = 7;

  typedef struct {
    logic [5:0] opc;
    int         fn;
    logic [3:0] aluc;
    bit         a_shamt;
    int         bsel;
    int         kind;
    bit         ovf;
    bit         bz;
  } op_t;

  typedef struct {
    logic [2:0] state;
    logic       halted;
    logic [3:0] aluc;
    logic       a_sel;
    logic [1:0] b_sel;
    logic       ir_we, pc_we, rf_we, dmem_req, dmem_we;
    logic [1:0] pc_sel, waddr, wdata;
    bit         chk_state, chk_alu, chk_pc, chk_rf;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    errors = 0;
  int    zero_mode = 2;
  int    ovf_mode = 2;
  bit    exp_valid = 1'b0;
  exp_t  e;
  op_t   ops[$];

  mc_ctrl_if bus();

  mc_ctrl #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic op_t mk(logic [5:0] opc, int fn, logic [3:0] aluc, bit a, int b,
                             int kind, bit ovf, bit bz);
    op_t o;
    o.opc = opc; o.fn = fn; o.aluc = aluc; o.a_shamt = a; o.bsel = b;
    o.kind = kind; o.ovf = ovf; o.bz = bz;
    return o;
  endfunction

  function automatic int lookup(logic [31:0] ins);
    int r;
    r = -1;
    foreach (ops[i])
      if (ops[i].opc == ins[31:26] && (ops[i].fn < 0 || ops[i].fn == int'(ins[5:0]))) r = i;
    return r;
  endfunction

  function automatic exp_t blank(logic [2:0] st);
    exp_t x;
    x.state = st; x.halted = 1'b0; x.aluc = '0; x.a_sel = 1'b0; x.b_sel = '0;
    x.ir_we = 0; x.pc_we = 0; x.rf_we = 0; x.dmem_req = 0; x.dmem_we = 0;
    x.pc_sel = '0; x.waddr = '0; x.wdata = '0;
    x.chk_state = 1; x.chk_alu = 0; x.chk_pc = 0; x.chk_rf = 0;
    return x;
  endfunction

  function automatic exp_t with_alu(exp_t x, op_t o);
    exp_t y;
    y = x;
    y.aluc = o.aluc; y.a_sel = o.a_shamt; y.b_sel = 2'(o.bsel); y.chk_alu = 1;
    return y;
  endfunction

  function automatic logic [31:0] make_instr(int idx);
    logic [31:0] r;
    r = $urandom;
    r[31:26] = ops[idx].opc;
    if (ops[idx].fn >= 0) r[5:0] = 6'(ops[idx].fn);
    return r;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      if (e.chk_state) begin
        chk("state", 32'(bus.state), 32'(e.state));
        chk("halted", 32'(bus.halted), 32'(e.halted));
      end
      chk("ir_we", 32'(bus.ir_we), 32'(e.ir_we));
      chk("pc_we", 32'(bus.pc_we), 32'(e.pc_we));
      chk("rf_we", 32'(bus.rf_we), 32'(e.rf_we));
      chk("dmem_req", 32'(bus.dmem_req), 32'(e.dmem_req));
      chk("dmem_we", 32'(bus.dmem_we), 32'(e.dmem_we));
      if (e.chk_pc) chk("pc_sel", 32'(bus.pc_sel), 32'(e.pc_sel));
      if (e.chk_alu) begin
        chk("aluc", 32'(bus.aluc), 32'(e.aluc));
        chk("alu_a_sel", 32'(bus.alu_a_sel), 32'(e.a_sel));
        chk("alu_b_sel", 32'(bus.alu_b_sel), 32'(e.b_sel));
      end
      if (e.chk_rf) begin
        chk("rf_waddr_sel", 32'(bus.rf_waddr_sel), 32'(e.waddr));
        chk("rf_wdata_sel", 32'(bus.rf_wdata_sel), 32'(e.wdata));
      end
    end
  end

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.alu_zero     = (zero_mode == 2) ? 1'($urandom) : 1'(zero_mode);
    bus.alu_overflow = (ovf_mode == 2) ? 1'($urandom) : 1'(ovf_mode);
    bus.dmem_ack     = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      cyc_begin();
      rst = 1'b1;
      x = blank(3'd0);
      // state only settles once the first reset edge has been taken
      x.chk_state = (i > 0);
      x.chk_alu = 1; x.chk_pc = 1; x.chk_rf = 1;
      e = x;
      exp_valid = 1'b1;
    end
  endtask

  task automatic go_halt();
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      cyc_begin();
      x = blank(3'd5);
      x.halted = 1'b1;
      e = x;
    end
    do_reset(2);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int ack_at, output int ncyc);
    int   idx;
    op_t  o;
    exp_t x;
    ncyc = 0;
    idx = lookup(ins);
    cyc_begin();
    bus.instr = ins;
    x = blank(3'd0); x.ir_we = 1; x.pc_we = 1; x.chk_pc = 1;
    e = x; ncyc++;
    cyc_begin();
    x = blank(3'd1); ncyc++;
    if (idx < 0) begin
      e = x;
      go_halt();
      return;
    end
    o = ops[idx];
    if (o.kind == K_J || o.kind == K_JAL) begin
      x.pc_we = 1; x.pc_sel = 2'd2; x.chk_pc = 1;
    end
    if (o.kind == K_JAL) begin
      x.rf_we = 1; x.waddr = 2'd2; x.wdata = 2'd2; x.chk_rf = 1;
    end
    if (o.kind == K_JR) begin
      x.pc_we = 1; x.pc_sel = 2'd3; x.chk_pc = 1;
    end
    e = x;
    if (o.kind == K_J || o.kind == K_JAL || o.kind == K_JR) return;
    cyc_begin();
    x = with_alu(blank(3'd2), o); ncyc++;
    if (o.kind == K_BR) begin
      x.pc_we = o.bz ? bus.alu_zero : !bus.alu_zero;
      x.pc_sel = 2'd1; x.chk_pc = x.pc_we;
      e = x;
      return;
    end
    e = x;
    if (o.kind == K_LW || o.kind == K_SW) begin
      for (int k = 1; k <= WAIT_MAX; k++) begin
        cyc_begin();
        bus.dmem_ack = (k == ack_at);
        x = with_alu(blank(3'd3), o);
        x.dmem_req = 1; x.dmem_we = (o.kind == K_SW);
        e = x; ncyc++;
        if (k == ack_at) begin
          if (o.kind == K_SW) return;
          break;
        end
        if (k == WAIT_MAX) begin
          go_halt();
          return;
        end
      end
    end
    cyc_begin();
    x = with_alu(blank(3'd4), o); ncyc++;
    x.rf_we = !(o.ovf && bus.alu_overflow);
    x.waddr = (o.kind == K_R) ? 2'd0 : 2'd1;
    x.wdata = (o.kind == K_LW) ? 2'd1 : 2'd0;
    x.chk_rf = 1;
    e = x;
  endtask

  task automatic pin(input string nm, input logic [31:0] ins, input int kind, input logic [3:0] aluc);
    int idx;
    idx = lookup(ins);
    chk({nm, "_kind"}, 32'((idx < 0) ? -1 : ops[idx].kind), 32'(kind));
    if (idx >= 0) chk({nm, "_aluc"}, 32'(ops[idx].aluc), 32'(aluc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    ops.push_back(mk(6'h00, 'h20, 4'b0010, 0, 0, K_R, 1, 0));
    ops.push_back(mk(6'h00, 'h21, 4'b0000, 0, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h22, 4'b0011, 0, 0, K_R, 1, 0));
    ops.push_back(mk(6'h00, 'h23, 4'b0001, 0, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h24, 4'b0100, 0, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h25, 4'b0101, 0, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h26, 4'b0110, 0, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h27, 4'b0111, 0, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h2A, 4'b1011, 0, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h2B, 4'b1010, 0, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h00, 4'b1111, 1, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h02, 4'b1101, 1, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h03, 4'b1100, 1, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h04, 4'b1111, 0, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h06, 4'b1101, 0, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h07, 4'b1100, 0, 0, K_R, 0, 0));
    ops.push_back(mk(6'h00, 'h08, 4'b0000, 0, 0, K_JR, 0, 0));
    ops.push_back(mk(6'h08, -1, 4'b0010, 0, 1, K_I, 1, 0));
    ops.push_back(mk(6'h09, -1, 4'b0000, 0, 1, K_I, 0, 0));
    ops.push_back(mk(6'h0A, -1, 4'b1011, 0, 1, K_I, 0, 0));
    ops.push_back(mk(6'h0B, -1, 4'b1010, 0, 1, K_I, 0, 0));
    ops.push_back(mk(6'h0C, -1, 4'b0100, 0, 2, K_I, 0, 0));
    ops.push_back(mk(6'h0D, -1, 4'b0101, 0, 2, K_I, 0, 0));
    ops.push_back(mk(6'h0E, -1, 4'b0110, 0, 2, K_I, 0, 0));
    ops.push_back(mk(6'h0F, -1, 4'b1000, 0, 2, K_I, 0, 0));
    ops.push_back(mk(6'h23, -1, 4'b0000, 0, 1, K_LW, 0, 0));
    ops.push_back(mk(6'h2B, -1, 4'b0000, 0, 1, K_SW, 0, 0));
    ops.push_back(mk(6'h04, -1, 4'b0001, 0, 0, K_BR, 0, 1));
    ops.push_back(mk(6'h05, -1, 4'b0001, 0, 0, K_BR, 0, 0));
    ops.push_back(mk(6'h02, -1, 4'b0000, 0, 0, K_J, 0, 0));
    ops.push_back(mk(6'h03, -1, 4'b0000, 0, 0, K_JAL, 0, 0));

    pin("pin_add", 32'h00221820, K_R, 4'b0010);
    pin("pin_beq", 32'h10220003, K_BR, 4'b0001);
    pin("pin_lw", 32'h8C280004, K_LW, 4'b0000);
    pin("pin_jal", 32'h0C000010, K_JAL, 4'b0000);
    chk("pin_illegal", 32'(lookup(32'hFC000000)), 32'hFFFFFFFF);

    bus.instr = '0; bus.alu_zero = 0; bus.alu_overflow = 0; bus.dmem_ack = 0;
    do_reset(2);

    ovf_mode = 0;
    run_instr(32'h00221820, 1, c); chk("add_cycles", 32'(c), 32'd4);
    ovf_mode = 1;
    run_instr(32'h00221820, 1, c); chk("add_ovf_cycles", 32'(c), 32'd4);
    ovf_mode = 2; zero_mode = 1;
    run_instr(32'h10220003, 1, c); chk("beq_taken_cycles", 32'(c), 32'd3);
    zero_mode = 0;
    run_instr(32'h10220003, 1, c); chk("beq_not_taken_cycles", 32'(c), 32'd3);
    zero_mode = 2;
    run_instr(32'h8C280004, 3, c); chk("lw_cycles", 32'(c), 32'd7);
    run_instr(32'h0C000010, 1, c); chk("jal_cycles", 32'(c), 32'd2);
    run_instr(32'hAC280004, 1, c); chk("sw_cycles", 32'(c), 32'd4);
    run_instr(32'hAC280004, 0, c);
    run_instr(32'hFC000000, 1, c);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] ins;
      int ack;
      if ($urandom_range(0, 29) == 0) begin
        ins = $urandom;
        case ($urandom_range(0, 2))
          0: ins[31:26] = 6'h3F;
          1: ins[31:26] = 6'h01;
          default: begin ins[31:26] = 6'h00; ins[5:0] = 6'h01; end
        endcase
      end else begin
        ins = make_instr($urandom_range(0, ops.size() - 1));
      end
      ack = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 5);
      run_instr(ins, ack, c);
    end

    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control unit for the MIPS-31 core. It sits directly upstream of the ALU: it decodes the instruction register, drives aluc and the operand-select muxes into the ALU, and consumes the ALU zero/overflow flags. It also sequences PC, IR, register-file and data-memory writes through a FETCH/DECODE/EXEC/MEM/WB state machine, with a req/ack handshake to data memory.

Parameters:
MEM_WAIT_MAX, 15, max cycles in MEM without dmem_ack before a bus-error halt (1..255)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
instr  in  32  current IR contents, stable from DECODE onward
alu_zero  in  1  ALU zero flag
alu_overflow  in  1  ALU overflow flag
dmem_ack  in  1  data memory done; sampled while dmem_req=1
aluc  out  4  ALU op: ADDU 0000, SUBU 0001, ADD 0010, SUB 0011, AND 0100, OR 0101, XOR 0110, NOR 0111, LUI 1000, SLTU 1010, SLT 1011, SRA 1100, SRL 1101, SLL 1111
alu_a_sel  out  1  0 = rs, 1 = zero-extended shamt
alu_b_sel  out  2  0 = rt, 1 = sign-ext imm16, 2 = zero-ext imm16
ir_we  out  1  load IR from imem
pc_we  out  1  PC write enable
pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs
rf_we  out  1  register-file write enable
rf_waddr_sel  out  2  0 = rd, 1 = rt, 2 = $31
rf_wdata_sel  out  2  0 = ALU result, 1 = dmem read data, 2 = PC (already PC+4)
dmem_req  out  1  data memory request
dmem_we  out  1  store when 1, load when 0
state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 5
halted  out  1  registered; 1 while in HALT

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. The rst edge forces state = FETCH, clears the wait counter and sets halted = 0.
- Gating during reset: while rst = 1, all write enables and dmem_req are forced to 0 combinationally. aluc = 0000 and all selects = 0.
- Output timing: outputs are decoded from the state register and instr. State advances only on clk.
- FETCH: ir_we = 1, pc_we = 1, pc_sel = 0. Next state is DECODE.
- DECODE:
  - j: pc_we = 1, pc_sel = 2, then FETCH.
  - jal: j signals plus rf_we = 1, rf_waddr_sel = 2, rf_wdata_sel = 2, then FETCH.
  - jr: pc_we = 1, pc_sel = 3, then FETCH.
  - Opcode/funct outside the 31-instruction set: go to HALT.
  - Otherwise: go to EXEC.
- EXEC: aluc and operand selects are per instruction:
  - R-type ALU ops: b = rt.
  - sll/srl/sra: a = shamt. sllv/srlv/srav: a = rs.
  - addi, addiu, slti, sltiu, lw, sw: b = sign-ext imm.
  - andi, ori, xori: b = zero-ext imm.
  - lui: aluc = 1000.
  - lw, sw: aluc = 0000.
  - beq/bne: aluc = 0001. Branch is taken when (beq & alu_zero) or (bne & !alu_zero); taken gives pc_we = 1, pc_sel = 1. Next state is FETCH.
  - lw/sw go to MEM. All others go to WB.
- MEM:
  - dmem_req = 1 is held and dmem_we = 1 for sw. The counter increments each MEM cycle.
  - An ack in the first MEM cycle is legal.
  - On ack: lw goes to WB, sw goes to FETCH, and the counter clears.
  - If the counter reaches MEM_WAIT_MAX with no ack, go to HALT and deassert dmem_req.
- WB: aluc and selects are held from EXEC.
  - rf_we = 1; rf_waddr_sel = 0 for R-type, 1 for I-type/lw.
  - rf_wdata_sel = 1 for lw, 0 otherwise.
  - add, sub, addi with alu_overflow = 1: rf_we = 0 (result discarded).
  - Next state is FETCH.
- HALT: all enables are 0. Only rst exits.
- Cycle counts: R/I ALU op 4, branch 3, j/jal/jr 2, sw 4 + wait, lw 5 + wait.

Decomposition:
- Package mc_ctrl_pkg holds the state encodings, aluc constants, opcode/funct constants and mux-select constants.
- One sub-module, mc_decoder (combinational): instr -> instruction class, aluc, alu_a_sel, alu_b_sel, rf_waddr_sel, illegal flag.
- mc_ctrl contains the FSM, wait counter and enable gating.

Test Plan:
- rst held 2 cycles, then released -> while rst is high all enables are 0. First cycle after release: state = 0, ir_we = 1, pc_we = 1, pc_sel = 0.
- instr 0x00221820 (add $3,$1,$2), alu_overflow = 0 -> states 0,1,2,4. In WB: aluc = 0010, rf_we = 1, rf_waddr_sel = 0. Repeat with alu_overflow = 1 -> rf_we = 0 in WB.
- instr 0x10220003 (beq) with alu_zero = 1 -> in EXEC: pc_we = 1, pc_sel = 1, aluc = 0001, then state 0. With alu_zero = 0 -> pc_we = 0 in EXEC.
- instr 0x8C280004 (lw), dmem_ack on the 3rd MEM cycle -> dmem_req = 1 for exactly 3 cycles, dmem_we = 0. Then WB with rf_wdata_sel = 1, rf_waddr_sel = 1. Total 7 cycles.
- sw, dmem_ack never asserted, MEM_WAIT_MAX = 15 -> HALT after 15 MEM cycles. halted = 1 and dmem_req = 0. Stays in HALT until rst.
- instr 0x0C000010 (jal) -> 2 cycles. In DECODE: pc_sel = 2, rf_we = 1, rf_waddr_sel = 2, rf_wdata_sel = 2. instr with opcode 0x3F -> HALT from DECODE.
